// File: rtl/shared_pkg.sv
// Shared types and defaults for the FIFO burst reader.
// Holds the reader FSM state enum and the data/length width defaults.
package shared_pkg;

    localparam int FIFO_WIDTH_DEF = 16;
    localparam int LEN_W_DEF      = 8;
    localparam int STAT_W         = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

    // Saturating increment for the statistics counters.
    function automatic logic [STAT_W-1:0] sat_inc(
        input logic [STAT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry output buffer between the FIFO read port and the stream output.
// Entry 0 is always the head; a simultaneous write and read is lossless when full.
module fifo_reader_skid #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic         valid,
    output logic [W-1:0] data,
    output logic [1:0]   occ
);

    logic [W-1:0] e0;
    logic [W-1:0] e1;
    logic [1:0]   cnt;

    // Shift/fill the two entries; head only moves on a read so it stays stable under backpressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0  <= '0;
            e1  <= '0;
            cnt <= 2'd0;
        end else begin
            unique case ({wr_en, rd_en})
                2'b10: begin
                    if (cnt == 2'd0) begin
                        e0 <= wr_data;
                    end else begin
                        e1 <= wr_data;
                    end
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    e0  <= e1;
                    cnt <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        e0 <= wr_data;
                    end else begin
                        e0 <= e1;
                        e1 <= wr_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign valid = (cnt != 2'd0);
    assign data  = e0;
    assign occ   = cnt;

endmodule

// File: rtl/fifo_reader.sv
// Burst reader: pulls burst_len words from a FIFO into a valid/ready stream.
// Define FIFO_READER_STATS_EN to add the stall_cnt / bp_cnt statistics outputs.
module fifo_reader
    import shared_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int LEN_W      = LEN_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_W-1:0]      burst_len,
    output logic                  fifo_rd_en,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err
`ifdef FIFO_READER_STATS_EN
    ,
    output logic [STAT_W-1:0]     stall_cnt,
    output logic [STAT_W-1:0]     bp_cnt
`endif
);

    rd_state_t           state;
    logic [LEN_W-1:0]    remaining;
    logic                in_flight;
    logic                flight_last;
    logic                rd_go;
    logic                last_issue;
    logic                pop;
    logic                buf_valid;
    logic                drain_done;
    logic [1:0]          occ;
    logic [1:0]          occ_eff;
    logic [FIFO_WIDTH:0] buf_word;

    // A word leaving this cycle frees its slot, so the read gate sees the
    // post-pop occupancy; this keeps one word per cycle under full flow.
    assign pop     = buf_valid & m_ready;
    assign occ_eff = occ - {1'b0, pop};

    assign rd_go = (state == RUN)
                 && !fifo_empty
                 && (remaining != '0)
                 && (({1'b0, occ_eff} + {2'b00, in_flight}) < 3'd2);

    assign last_issue = rd_go && (remaining == LEN_W'(1));

    // Drain ends once nothing is in flight and the buffer empties this cycle
    assign drain_done = !in_flight
                      && ((occ == 2'd0) || ((occ == 2'd1) && pop));

    assign fifo_rd_en = rd_go;

    // Burst FSM with read bookkeeping, sticky error and registered status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            remaining   <= '0;
            in_flight   <= 1'b0;
            flight_last <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            in_flight   <= rd_go;
            flight_last <= last_issue;
            done        <= 1'b0;
            if (rd_go) begin
                remaining <= remaining - 1'b1;
            end
            if (in_flight && fifo_underflow) begin
                err <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        err       <= 1'b0;
                        remaining <= burst_len;
                        if (burst_len != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (last_issue) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    fifo_reader_skid #(
        .W(FIFO_WIDTH + 1)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (in_flight),
        .wr_data({flight_last, fifo_data_out}),
        .rd_en  (pop),
        .valid  (buf_valid),
        .data   (buf_word),
        .occ    (occ)
    );

    assign m_valid = buf_valid;
    assign m_data  = buf_word[FIFO_WIDTH-1:0];
    assign m_last  = buf_valid & buf_word[FIFO_WIDTH];

`ifdef FIFO_READER_STATS_EN
    // Stall and backpressure counters, restarted by each accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            bp_cnt    <= '0;
        end else if ((state == IDLE) && start) begin
            stall_cnt <= '0;
            bp_cnt    <= '0;
        end else begin
            if ((state == RUN) && fifo_empty) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (buf_valid && !m_ready) begin
                bp_cnt <= sat_inc(bp_cnt);
            end
        end
    end
`endif

endmodule
